pc_round_ctrl: RTL and testbench

//  Iterative round controller and constant-addition stage (pC) of the ASCON

---
 rtl/pc_round_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_round_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_round_ctrl.sv
// pc_round_ctrl: round controller and constant-addition stage (pC) of the
// ASCON permutation. It holds the 320-bit state and the round counter, XORs
// the round constant into x2, and drives the result to the S-box layer. The
// post-linear-layer state returns on feedback_i at one round per cycle.
// Supports p^6, p^8 and p^12.
//
// Ports
//   clock_i      in   system clock, rising edge
//   reset_i      in   synchronous active-high reset
//   start_i      in   request a permutation (accepted only while ready_o=1)
//   nb_rounds_i  in   rounds to run: 6, 8 or 12 (sampled with start_i)
//   state_i      in   initial state (sampled with start_i)
//   feedback_i   in   state returned from the linear layer for the current round
//   pc_out_o     out  state with round constant added, to the S-box layer
//   round_o      out  current round index
//   valid_o      out  pc_out_o carries a live round
//   ready_o      out  idle, a start will be accepted
//   done_o       out  one-cycle pulse, state_o holds the result
//   err_o        out  one-cycle pulse, start rejected for illegal nb_rounds_i
//   state_o      out  final permutation result, held until the next run ends
//
// state  | meaning
// S_IDLE | waiting for start, ready_o=1
// S_RUN  | one round per cycle, valid_o=1
// S_DONE | result available, done_o pulse
module pc_round_ctrl #(
  parameter int NR_MAX = 12
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       nb_rounds_i,
  input  logic [4:0][63:0] state_i,
  input  logic [4:0][63:0] feedback_i,
  output logic [4:0][63:0] pc_out_o,
  output logic [3:0]       round_o,
  output logic             valid_o,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [4:0][63:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR_MAX - 1);
  localparam logic [3:0] NR_TOTAL   = 4'(NR_MAX);

  fsm_t             r_fsm;
  fsm_t             w_fsm_d;
  logic [4:0][63:0] r_state_q;
  logic [4:0][63:0] r_state_o;
  logic [3:0]       r_round;
  logic             r_err;
  logic             w_err_d;
  logic             w_load;
  logic             w_nb_ok;
  logic             w_last;
  logic [7:0]       w_rc;

  assign w_nb_ok = (nb_rounds_i == 4'd6) || (nb_rounds_i == 4'd8) ||
                   (nb_rounds_i == 4'd12);
  assign w_last  = (r_round == LAST_ROUND);

  always_comb begin
    w_fsm_d = r_fsm;
    w_load  = 1'b0;
    w_err_d = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start_i) begin
          if (w_nb_ok) begin
            w_load  = 1'b1;
            w_fsm_d = S_RUN;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_last) w_fsm_d = S_DONE;
      end
      S_DONE:  w_fsm_d = S_IDLE;
      default: w_fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_fsm     <= S_IDLE;
      r_state_q <= '0;
      r_state_o <= '0;
      r_round   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_fsm <= w_fsm_d;
      r_err <= w_err_d;
      if (w_load) begin
        r_state_q <= state_i;
        // shorter permutations run the tail of the p^12 schedule
        r_round   <= NR_TOTAL - nb_rounds_i;
      end else if (r_fsm == S_RUN) begin
        r_state_q <= feedback_i;
        if (w_last) begin
          r_state_o <= feedback_i;
        end else begin
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

  // round constant: high nibble counts down from F while low nibble counts up
  assign w_rc = {4'hF - r_round, r_round};

  always_comb begin
    pc_out_o       = r_state_q;
    pc_out_o[2][7:0] = r_state_q[2][7:0] ^ w_rc;
  end

  assign round_o = r_round;
  assign valid_o = (r_fsm == S_RUN);
  assign ready_o = (r_fsm == S_IDLE);
  assign done_o  = (r_fsm == S_DONE);
  assign err_o   = r_err;
  assign state_o = r_state_o;

endmodule

// File: tb/tb_pc_round_ctrl.sv
module tb_pc_round_ctrl;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       nb_rounds;
  logic [4:0][63:0] state_in;
  logic [4:0][63:0] feedback;
  logic [4:0][63:0] pc_out;
  logic [3:0]       round_o;
  logic             valid, ready, done, err;
  logic [4:0][63:0] state_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] seen [12];

  always #5 clk = ~clk;

  // feedback path stands in for pS/pL as an identity, so only pC acts
  assign feedback = pc_out;

  pc_round_ctrl #(.NR_MAX(12)) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .start_i     (start),
    .nb_rounds_i (nb_rounds),
    .state_i     (state_in),
    .feedback_i  (feedback),
    .pc_out_o    (pc_out),
    .round_o     (round_o),
    .valid_o     (valid),
    .ready_o     (ready),
    .done_o      (done),
    .err_o       (err),
    .state_o     (state_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one permutation in loopback. A stray start (nb=12, all-ones state)
  // is pushed during round iteration `poke` (use -1 for none).
  task automatic run_perm(input logic [3:0] nb, input logic [4:0][63:0] s_in,
                          input logic [4:0][63:0] exp_out, input int poke);
    logic [7:0]       model;
    logic [3:0]       r;
    logic [4:0][63:0] exp_pc;
    start = 1'b1; nb_rounds = nb; state_in = s_in;
    step();
    start = 1'b0; state_in = '0;
    chk("run_ready", 320'(ready), 320'(1'b0));
    model = s_in[2][7:0];
    r = 4'd12 - nb;
    for (int i = 0; i < int'(nb); i++) begin
      model  = model ^ {4'hF - r, r};
      exp_pc = s_in;
      exp_pc[2][7:0] = model;
      chk("run_valid", 320'(valid), 320'(1'b1));
      chk("round", 320'(round_o), 320'(r));
      chk("pc_out", pc_out, exp_pc);
      chk("no_early_done", 320'(done), 320'(1'b0));
      seen[i] = pc_out[2][7:0];
      if (i == poke) begin
        start = 1'b1; nb_rounds = 4'd12; state_in = '1;
      end
      step();
      start = 1'b0; state_in = '0;
      r = r + 4'd1;
    end
    chk("done_pulse", 320'(done), 320'(1'b1));
    chk("done_valid", 320'(valid), 320'(1'b0));
    chk("done_ready", 320'(ready), 320'(1'b0));
    chk("result", state_out, exp_out);
    step();
    chk("done_single", 320'(done), 320'(1'b0));
    chk("idle_ready", 320'(ready), 320'(1'b1));
    chk("result_held", state_out, exp_out);
  endtask

  initial begin
    logic [4:0][63:0] s, e;
    reset = 1'b1; start = 1'b0; nb_rounds = 4'd0; state_in = '0;

    // reset
    step(); step();
    chk("rst_ready", 320'(ready), 320'(1'b1));
    chk("rst_valid", 320'(valid), 320'(1'b0));
    chk("rst_done", 320'(done), 320'(1'b0));
    chk("rst_err", 320'(err), 320'(1'b0));
    chk("rst_state_o", state_out, 320'd0);
    chk("rst_round", 320'(round_o), 320'd0);
    chk("rst_pc_byte", 320'(pc_out[2][7:0]), 320'(8'hF0));
    reset = 1'b0;
    step();

    // p^6 from zero: x2 byte accumulates 96,87,78,69,5A,4B
    e = '0; e[2] = 64'h11;
    run_perm(4'd6, '0, e, -1);
    chk("p6_b0", 320'(seen[0]), 320'(8'h96));
    chk("p6_b1", 320'(seen[1]), 320'(8'h11));
    chk("p6_b2", 320'(seen[2]), 320'(8'h69));
    chk("p6_b3", 320'(seen[3]), 320'(8'h00));
    chk("p6_b4", 320'(seen[4]), 320'(8'h5A));
    chk("p6_b5", 320'(seen[5]), 320'(8'h11));

    // p^12 and p^8 from zero: all constants cancel
    run_perm(4'd12, '0, '0, -1);
    chk("p12_first", 320'(seen[0]), 320'(8'hF0));
    run_perm(4'd8, '0, '0, -1);
    chk("p8_first", 320'(seen[0]), 320'(8'hB4));

    // illegal round counts
    start = 1'b1; nb_rounds = 4'd5; state_in = '1;
    step();
    start = 1'b0;
    chk("err5_pulse", 320'(err), 320'(1'b1));
    chk("err5_ready", 320'(ready), 320'(1'b1));
    chk("err5_valid", 320'(valid), 320'(1'b0));
    step();
    chk("err5_single", 320'(err), 320'(1'b0));
    chk("err5_state_o", state_out, 320'd0);
    start = 1'b1; nb_rounds = 4'd13;
    step();
    start = 1'b0; state_in = '0;
    chk("err13_pulse", 320'(err), 320'(1'b1));
    chk("err13_ready", 320'(ready), 320'(1'b1));

    // legal p^6 on a non-zero state with a start pushed mid-run
    s = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A5A5A5A55A,
         64'h0F0F0F0F0F0F0F0F, 64'hDEADBEEFCAFEF00D};
    e = s; e[2][7:0] = 8'h5A ^ 8'h11;
    run_perm(4'd6, s, e, 2);
    chk("poke_no_err", 320'(err), 320'(1'b0));

    // reset during round 3 of p^12
    start = 1'b1; nb_rounds = 4'd12; state_in = s;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("mid_round3", 320'(round_o), 320'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ready", 320'(ready), 320'(1'b1));
    chk("abort_valid", 320'(valid), 320'(1'b0));
    chk("abort_state_o", state_out, 320'd0);
    chk("abort_round", 320'(round_o), 320'd0);
    chk("abort_done", 320'(done), 320'(1'b0));
    step();
    chk("abort_no_done", 320'(done), 320'(1'b0));

    // normal p^8 afterwards: constants cancel, state returns unchanged
    run_perm(4'd8, s, s, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
